// File: rtl/tl_a_arbiter_if.sv
// Bundle of client A/D and manager A/D channel signals around the TileLink A-channel arbiter.
// "master" is the arbiter's view; "slave" is the view of the clients and manager around it.
interface tl_a_arbiter_if #(
    parameter int N_CLIENTS = 2,
    parameter int IDX_W     = 1,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int SOURCE_W  = 4,
    parameter int SINK_W    = 4
);
    localparam int MASK_W = DATA_W / 8;
    localparam int MSRC_W = SOURCE_W + IDX_W;

    logic [N_CLIENTS-1:0]          c_a_valid;
    logic [N_CLIENTS-1:0]          c_a_ready;
    logic [N_CLIENTS*3-1:0]        c_a_opcode;
    logic [N_CLIENTS*3-1:0]        c_a_param;
    logic [N_CLIENTS*4-1:0]        c_a_size;
    logic [N_CLIENTS*SOURCE_W-1:0] c_a_source;
    logic [N_CLIENTS*ADDR_W-1:0]   c_a_address;
    logic [N_CLIENTS*MASK_W-1:0]   c_a_mask;
    logic [N_CLIENTS*DATA_W-1:0]   c_a_data;

    logic                          m_a_valid;
    logic                          m_a_ready;
    logic [2:0]                    m_a_opcode;
    logic [2:0]                    m_a_param;
    logic [3:0]                    m_a_size;
    logic [MSRC_W-1:0]             m_a_source;
    logic [ADDR_W-1:0]             m_a_address;
    logic [MASK_W-1:0]             m_a_mask;
    logic [DATA_W-1:0]             m_a_data;

    logic                          m_d_valid;
    logic                          m_d_ready;
    logic [2:0]                    m_d_opcode;
    logic [1:0]                    m_d_param;
    logic [3:0]                    m_d_size;
    logic [SINK_W-1:0]             m_d_sink;
    logic                          m_d_denied;
    logic [DATA_W-1:0]             m_d_data;
    logic [MSRC_W-1:0]             m_d_source;

    logic [N_CLIENTS-1:0]          c_d_valid;
    logic [N_CLIENTS-1:0]          c_d_ready;
    logic [2:0]                    c_d_opcode;
    logic [1:0]                    c_d_param;
    logic [3:0]                    c_d_size;
    logic [SINK_W-1:0]             c_d_sink;
    logic                          c_d_denied;
    logic [DATA_W-1:0]             c_d_data;
    logic [SOURCE_W-1:0]           c_d_source;

    logic                          busy;
    logic [IDX_W-1:0]              grant_idx;

    modport master (
        input  c_a_valid, c_a_opcode, c_a_param, c_a_size, c_a_source, c_a_address, c_a_mask, c_a_data,
        output c_a_ready,
        output m_a_valid, m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address, m_a_mask, m_a_data,
        input  m_a_ready,
        input  m_d_valid, m_d_opcode, m_d_param, m_d_size, m_d_sink, m_d_denied, m_d_data, m_d_source,
        output m_d_ready,
        output c_d_valid, c_d_opcode, c_d_param, c_d_size, c_d_sink, c_d_denied, c_d_data, c_d_source,
        input  c_d_ready,
        output busy, grant_idx
    );

    modport slave (
        output c_a_valid, c_a_opcode, c_a_param, c_a_size, c_a_source, c_a_address, c_a_mask, c_a_data,
        input  c_a_ready,
        input  m_a_valid, m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address, m_a_mask, m_a_data,
        output m_a_ready,
        output m_d_valid, m_d_opcode, m_d_param, m_d_size, m_d_sink, m_d_denied, m_d_data, m_d_source,
        input  m_d_ready,
        input  c_d_valid, c_d_opcode, c_d_param, c_d_size, c_d_sink, c_d_denied, c_d_data, c_d_source,
        output c_d_ready,
        input  busy, grant_idx
    );
endinterface

// File: rtl/tl_a_arbiter.sv
// Round-robin TileLink A-channel arbiter with burst locking and source-indexed D routing.
// The grant is frozen once a beat is offered, so a stalled beat never changes owner.
module tl_a_arbiter #(
    parameter int N_CLIENTS = 2,
    parameter int IDX_W     = 1,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int SOURCE_W  = 4,
    parameter int SINK_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    tl_a_arbiter_if.master   bus
);
    localparam int         MASK_W  = DATA_W / 8;
    localparam int         MSRC_W  = SOURCE_W + IDX_W;
    localparam logic [3:0] BEAT_LG = 4'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, BURST = 2'd2} state_e;

    state_e              state_r, state_nxt_s;
    logic [IDX_W-1:0]    rr_ptr_r, rr_ptr_nxt_s;
    logic [IDX_W-1:0]    lock_idx_r, lock_idx_nxt_s;
    logic [2:0]          beat_cnt_r, beat_cnt_nxt_s;

    logic [IDX_W-1:0]    winner_s, grant_s, d_idx_s;
    int                  best_d_s, dist_s;
    logic                sel_valid_s, m_a_valid_s, hs_s, multi_s;
    logic [2:0]          sel_opcode_s, sel_param_s;
    logic [3:0]          sel_size_s;
    logic [SOURCE_W-1:0] sel_source_s;
    logic [ADDR_W-1:0]   sel_address_s;
    logic [MASK_W-1:0]   sel_mask_s;
    logic [DATA_W-1:0]   sel_data_s;

    function automatic logic is_multi(input logic [2:0] op, input logic [3:0] sz);
        return ((op == 3'd0) || (op == 3'd1)) && (sz > BEAT_LG);
    endfunction

    // Beats remaining after the first one, minus one: the burst counter's start value.
    function automatic logic [2:0] beats_m2(input logic [3:0] sz);
        logic [15:0] b;
        b = (16'd1 << (sz - BEAT_LG)) - 16'd2;
        return b[2:0];
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) >= N_CLIENTS - 1) begin
            return {IDX_W{1'b0}};
        end else begin
            return i + IDX_W'(32'd1);
        end
    endfunction

    // Round-robin winner: valid client at the smallest forward distance from rr_ptr.
    always_comb begin
        winner_s = rr_ptr_r;
        best_d_s = N_CLIENTS;
        dist_s   = 0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            dist_s = (i >= int'(rr_ptr_r)) ? (i - int'(rr_ptr_r)) : (i + N_CLIENTS - int'(rr_ptr_r));
            if (bus.c_a_valid[i] && (dist_s < best_d_s)) begin
                best_d_s = dist_s;
                winner_s = IDX_W'(i);
            end else begin
                best_d_s = best_d_s;
            end
        end
    end

    assign grant_s = (state_r == IDLE) ? winner_s : lock_idx_r;

    // AND-OR mux of the granted client's A fields.
    always_comb begin
        sel_valid_s   = 1'b0;
        sel_opcode_s  = 3'd0;
        sel_param_s   = 3'd0;
        sel_size_s    = 4'd0;
        sel_source_s  = {SOURCE_W{1'b0}};
        sel_address_s = {ADDR_W{1'b0}};
        sel_mask_s    = {MASK_W{1'b0}};
        sel_data_s    = {DATA_W{1'b0}};
        for (int i = 0; i < N_CLIENTS; i++) begin
            sel_valid_s   |= (grant_s == IDX_W'(i)) & bus.c_a_valid[i];
            sel_opcode_s  |= (grant_s == IDX_W'(i)) ? bus.c_a_opcode[i*3 +: 3] : 3'd0;
            sel_param_s   |= (grant_s == IDX_W'(i)) ? bus.c_a_param[i*3 +: 3] : 3'd0;
            sel_size_s    |= (grant_s == IDX_W'(i)) ? bus.c_a_size[i*4 +: 4] : 4'd0;
            sel_source_s  |= (grant_s == IDX_W'(i)) ? bus.c_a_source[i*SOURCE_W +: SOURCE_W] : {SOURCE_W{1'b0}};
            sel_address_s |= (grant_s == IDX_W'(i)) ? bus.c_a_address[i*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}};
            sel_mask_s    |= (grant_s == IDX_W'(i)) ? bus.c_a_mask[i*MASK_W +: MASK_W] : {MASK_W{1'b0}};
            sel_data_s    |= (grant_s == IDX_W'(i)) ? bus.c_a_data[i*DATA_W +: DATA_W] : {DATA_W{1'b0}};
        end
    end

    assign m_a_valid_s = (state_r == IDLE) ? (|bus.c_a_valid) : sel_valid_s;
    assign hs_s        = m_a_valid_s && bus.m_a_ready;
    assign multi_s     = is_multi(sel_opcode_s, sel_size_s);

    // Next-state logic for the grant FSM, round-robin pointer and burst counter.
    always_comb begin
        state_nxt_s    = state_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        lock_idx_nxt_s = lock_idx_r;
        beat_cnt_nxt_s = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (hs_s && multi_s) begin
                    lock_idx_nxt_s = winner_s;
                    beat_cnt_nxt_s = beats_m2(sel_size_s);
                    state_nxt_s    = BURST;
                end else if (hs_s) begin
                    rr_ptr_nxt_s   = next_idx(winner_s);
                end else if (m_a_valid_s) begin
                    lock_idx_nxt_s = winner_s;
                    state_nxt_s    = HOLD;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            HOLD: begin
                if (hs_s && multi_s) begin
                    beat_cnt_nxt_s = beats_m2(sel_size_s);
                    state_nxt_s    = BURST;
                end else if (hs_s) begin
                    rr_ptr_nxt_s   = next_idx(lock_idx_r);
                    state_nxt_s    = IDLE;
                end else begin
                    state_nxt_s    = HOLD;
                end
            end
            BURST: begin
                if (hs_s && (beat_cnt_r == 3'd0)) begin
                    rr_ptr_nxt_s   = next_idx(lock_idx_r);
                    state_nxt_s    = IDLE;
                end else if (hs_s) begin
                    beat_cnt_nxt_s = beat_cnt_r - 3'd1;
                end else begin
                    state_nxt_s    = BURST;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            rr_ptr_r   <= {IDX_W{1'b0}};
            lock_idx_r <= {IDX_W{1'b0}};
            beat_cnt_r <= 3'd0;
        end else begin
            state_r    <= state_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            lock_idx_r <= lock_idx_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

    assign bus.m_a_opcode  = sel_opcode_s;
    assign bus.m_a_param   = sel_param_s;
    assign bus.m_a_size    = sel_size_s;
    assign bus.m_a_source  = {grant_s, sel_source_s};
    assign bus.m_a_address = sel_address_s;
    assign bus.m_a_mask    = sel_mask_s;
    assign bus.m_a_data    = sel_data_s;

    // A-side handshake outputs, all forced low while in reset.
    always_comb begin
        bus.m_a_valid = 1'b0;
        bus.c_a_ready = {N_CLIENTS{1'b0}};
        bus.busy      = 1'b0;
        bus.grant_idx = {IDX_W{1'b0}};
        if (rst) begin
            bus.m_a_valid = 1'b0;
        end else begin
            bus.m_a_valid = m_a_valid_s;
            bus.busy      = (state_r != IDLE);
            bus.grant_idx = grant_s;
            for (int i = 0; i < N_CLIENTS; i++) begin
                bus.c_a_ready[i] = bus.m_a_ready && m_a_valid_s && (grant_s == IDX_W'(i));
            end
        end
    end

    assign d_idx_s = bus.m_d_source[MSRC_W-1:SOURCE_W];

    // D routing: responses whose index names no client are accepted and dropped.
    always_comb begin
        bus.c_d_valid = {N_CLIENTS{1'b0}};
        bus.m_d_ready = 1'b0;
        if (rst) begin
            bus.m_d_ready = 1'b0;
        end else begin
            bus.m_d_ready = 1'b1;
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (d_idx_s == IDX_W'(i)) begin
                    bus.c_d_valid[i] = bus.m_d_valid;
                    bus.m_d_ready    = bus.c_d_ready[i];
                end else begin
                    bus.c_d_valid[i] = 1'b0;
                end
            end
        end
    end

    assign bus.c_d_opcode = bus.m_d_opcode;
    assign bus.c_d_param  = bus.m_d_param;
    assign bus.c_d_size   = bus.m_d_size;
    assign bus.c_d_sink   = bus.m_d_sink;
    assign bus.c_d_denied = bus.m_d_denied;
    assign bus.c_d_data   = bus.m_d_data;
    assign bus.c_d_source = bus.m_d_source[SOURCE_W-1:0];
endmodule

// File: tb/tb_tl_a_arbiter.sv
// Testbench for tl_a_arbiter: directed scenarios plus randomized traffic, both checked every
// cycle against a message-level model (owner client, beats left, round-robin pointer).
module tb_tl_a_arbiter;
    localparam int N  = 2;
    localparam int IW = 1;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = 4;
    localparam int KW = 4;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tl_a_arbiter_if #(.N_CLIENTS(N), .IDX_W(IW), .ADDR_W(AW), .DATA_W(DW), .SOURCE_W(SW), .SINK_W(KW)) bus ();
    tl_a_arbiter #(.N_CLIENTS(N), .IDX_W(IW), .ADDR_W(AW), .DATA_W(DW), .SOURCE_W(SW), .SINK_W(KW))
        u_dut (.clk(clk), .rst(rst), .bus(bus));

    // Three-client instance: the only way to present a D index that names no client.
    tl_a_arbiter_if #(.N_CLIENTS(3), .IDX_W(2), .ADDR_W(AW), .DATA_W(DW), .SOURCE_W(SW), .SINK_W(KW)) bus3 ();
    tl_a_arbiter #(.N_CLIENTS(3), .IDX_W(2), .ADDR_W(AW), .DATA_W(DW), .SOURCE_W(SW), .SINK_W(KW))
        u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int vectors = 0;
    int miscompares = 0;

    // Model state: client owning the manager port (-1 none), beats left in its message, rr pointer.
    int m_owner = -1;
    int m_left  = 0;
    int m_rr    = 0;
    logic [N-1:0] exp_rdy;

    // Client stimulus state.
    logic        gv     [N];
    int          g_left [N];
    logic [2:0]  f_op   [N];
    logic [2:0]  f_param[N];
    logic [3:0]  f_sz   [N];
    logic [3:0]  f_src  [N];
    logic [63:0] f_addr [N];
    logic [7:0]  f_mask [N];
    logic [63:0] f_data [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int beats_of(input int op, input int sz);
        if ((op == 0 || op == 1) && sz > 3) return 1 << (sz - 3);
        return 1;
    endfunction

    task automatic drive_clients();
        for (int i = 0; i < N; i++) begin
            bus.c_a_valid[i]             = gv[i];
            bus.c_a_opcode[i*3 +: 3]     = f_op[i];
            bus.c_a_param[i*3 +: 3]      = f_param[i];
            bus.c_a_size[i*4 +: 4]       = f_sz[i];
            bus.c_a_source[i*SW +: SW]   = f_src[i];
            bus.c_a_address[i*AW +: AW]  = f_addr[i];
            bus.c_a_mask[i*MW +: MW]     = f_mask[i];
            bus.c_a_data[i*DW +: DW]     = f_data[i];
        end
    endtask

    task automatic set_client(input int i, input logic v, input logic [2:0] op, input logic [3:0] sz,
                              input logic [3:0] src, input logic [63:0] addr, input logic [63:0] data);
        gv[i] = v; f_op[i] = op; f_sz[i] = sz; f_src[i] = src; f_addr[i] = addr; f_data[i] = data;
        f_param[i] = 3'd0; f_mask[i] = 8'hFF;
    endtask

    // Compare the DUT outputs for the current inputs, then advance the model past the coming edge.
    task automatic model_check();
        int g, d_idx, op_g, sz_g;
        logic mv, found;
        logic [N-1:0] exp_cdv;
        logic exp_mdr;
        logic [63:0] exp_src;
        exp_rdy = '0;
        if (rst) begin
            chk("rst_m_a_valid", bus.m_a_valid, 1'b0);
            chk("rst_busy", bus.busy, 1'b0);
            chk("rst_grant", bus.grant_idx, 1'b0);
            chk("rst_c_a_ready", bus.c_a_ready, 2'b00);
            chk("rst_c_d_valid", bus.c_d_valid, 2'b00);
            chk("rst_m_d_ready", bus.m_d_ready, 1'b0);
            m_owner = -1; m_left = 0; m_rr = 0;
            return;
        end
        g = m_rr;
        if (m_owner >= 0) begin
            g = m_owner;
        end else begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && bus.c_a_valid[(m_rr + k) % N]) begin
                    g = (m_rr + k) % N;
                    found = 1'b1;
                end
            end
        end
        mv = (m_owner >= 0) ? bus.c_a_valid[m_owner] : (|bus.c_a_valid);
        if (mv && bus.m_a_ready) exp_rdy[g] = 1'b1;
        chk("m_a_valid", bus.m_a_valid, mv);
        chk("busy", bus.busy, m_owner >= 0);
        chk("c_a_ready", bus.c_a_ready, exp_rdy);
        op_g = int'(bus.c_a_opcode[g*3 +: 3]);
        sz_g = int'(bus.c_a_size[g*4 +: 4]);
        if (mv) begin
            exp_src = (64'(g) << SW) | 64'(bus.c_a_source[g*SW +: SW]);
            chk("grant_idx", bus.grant_idx, 64'(g));
            chk("m_a_opcode", bus.m_a_opcode, 64'(op_g));
            chk("m_a_param", bus.m_a_param, bus.c_a_param[g*3 +: 3]);
            chk("m_a_size", bus.m_a_size, 64'(sz_g));
            chk("m_a_source", bus.m_a_source, exp_src);
            chk("m_a_address", bus.m_a_address, bus.c_a_address[g*AW +: AW]);
            chk("m_a_mask", bus.m_a_mask, bus.c_a_mask[g*MW +: MW]);
            chk("m_a_data", bus.m_a_data, bus.c_a_data[g*DW +: DW]);
        end
        d_idx = int'(bus.m_d_source) >> SW;
        exp_cdv = '0;
        exp_mdr = 1'b1;
        if (d_idx < N) begin
            exp_cdv[d_idx] = bus.m_d_valid;
            exp_mdr = bus.c_d_ready[d_idx];
        end
        chk("c_d_valid", bus.c_d_valid, exp_cdv);
        chk("m_d_ready", bus.m_d_ready, exp_mdr);
        if (bus.m_d_valid) begin
            chk("c_d_source", bus.c_d_source, 64'(int'(bus.m_d_source) % 16));
            chk("c_d_data", bus.c_d_data, bus.m_d_data);
            chk("c_d_opcode", bus.c_d_opcode, bus.m_d_opcode);
            chk("c_d_param", bus.c_d_param, bus.m_d_param);
            chk("c_d_size", bus.c_d_size, bus.m_d_size);
            chk("c_d_sink", bus.c_d_sink, bus.m_d_sink);
            chk("c_d_denied", bus.c_d_denied, bus.m_d_denied);
        end
        if (mv) begin
            if (m_owner < 0) begin
                m_owner = g;
                m_left  = beats_of(op_g, sz_g);
            end
            if (bus.m_a_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_owner = -1;
                    m_rr    = (g + 1) % N;
                end
            end
        end
    endtask

    task automatic eval();
        drive_clients();
        #1;
        model_check();
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int busy_cnt;
        for (int i = 0; i < N; i++) begin
            set_client(i, 1'b0, 3'd4, 4'd0, 4'd0, 64'd0, 64'd0);
            g_left[i] = 0;
        end
        bus.m_a_ready = 1'b0; bus.m_d_valid = 1'b0; bus.c_d_ready = 2'b00;
        bus.m_d_opcode = 3'd0; bus.m_d_param = 2'd0; bus.m_d_size = 4'd0; bus.m_d_sink = 4'd0;
        bus.m_d_denied = 1'b0; bus.m_d_data = 64'd0; bus.m_d_source = 5'd0;
        bus3.c_a_valid = 3'b000; bus3.c_a_opcode = '0; bus3.c_a_param = '0; bus3.c_a_size = '0;
        bus3.c_a_source = '0; bus3.c_a_address = '0; bus3.c_a_mask = '0; bus3.c_a_data = '0;
        bus3.m_a_ready = 1'b0; bus3.m_d_valid = 1'b0; bus3.c_d_ready = 3'b000;
        bus3.m_d_opcode = 3'd0; bus3.m_d_param = 2'd0; bus3.m_d_size = 4'd0; bus3.m_d_sink = 4'd0;
        bus3.m_d_denied = 1'b0; bus3.m_d_data = 64'd0; bus3.m_d_source = 6'd0;
        tick();

        // Reset with traffic pending on every input: all handshake outputs must stay low.
        rst = 1'b1; bus.m_a_ready = 1'b1; bus.m_d_valid = 1'b1; bus.c_d_ready = 2'b11;
        set_client(0, 1'b1, 3'd4, 4'd3, 4'd2, 64'h100, 64'hA0);
        set_client(1, 1'b1, 3'd4, 4'd3, 4'd5, 64'h200, 64'hB0);
        eval(); tick();

        // Two Gets: client 0 first, then client 1 by rotation.
        rst = 1'b0; bus.m_d_valid = 1'b0;
        eval();
        chk("t1_grant_c0", bus.grant_idx, 1'b0);
        chk("t1_src_c0", bus.m_a_source, 5'h02);
        tick();
        eval();
        chk("t1_grant_c1", bus.grant_idx, 1'b1);
        chk("t1_src_c1", bus.m_a_source, 5'h15);
        tick();

        // 8-beat PutFull from client 0 holds off client 1's Get.
        busy_cnt = 0;
        for (int b = 0; b < 9; b++) begin
            set_client(0, 1'b1, 3'd0, 4'd6, 4'd1, 64'h400, 64'(b));
            eval();
            if (b < 8) begin
                chk("t2_burst_grant", bus.grant_idx, 1'b0);
                chk("t2_burst_data", bus.m_a_data, 64'(b));
            end else begin
                chk("t2_after_grant", bus.grant_idx, 1'b1);
                chk("t2_after_opcode", bus.m_a_opcode, 3'd4);
            end
            busy_cnt += int'(bus.busy);
            tick();
        end
        chk("t2_busy_cycles", 64'(busy_cnt), 64'd7);

        // Stalled beat: grant and payload frozen while client 1 competes.
        bus.m_a_ready = 1'b0;
        set_client(0, 1'b1, 3'd4, 4'd3, 4'd7, 64'h1234, 64'h55);
        set_client(1, 1'b0, 3'd4, 4'd3, 4'd5, 64'h200, 64'hB0);
        eval(); chk("t3_first_grant", bus.grant_idx, 1'b0); tick();
        gv[1] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            eval();
            chk("t3_stall_grant", bus.grant_idx, 1'b0);
            chk("t3_stall_addr", bus.m_a_address, 64'h1234);
            chk("t3_stall_ready", bus.c_a_ready, 2'b00);
            tick();
        end
        bus.m_a_ready = 1'b1;
        eval(); chk("t3_release_ready", bus.c_a_ready, 2'b01); tick();
        gv[0] = 1'b0;
        eval(); chk("t3_next_grant", bus.grant_idx, 1'b1); tick();
        gv[1] = 1'b0;

        // D response to client 1 with back-pressure, then accepted.
        bus.m_d_valid = 1'b1; bus.m_d_source = 5'h13; bus.c_d_ready = 2'b01; bus.m_d_data = 64'hD00D;
        eval();
        chk("t4_c_d_valid", bus.c_d_valid, 2'b10);
        chk("t4_c_d_source", bus.c_d_source, 4'd3);
        chk("t4_m_d_ready_lo", bus.m_d_ready, 1'b0);
        tick();
        bus.c_d_ready = 2'b11;
        eval(); chk("t4_m_d_ready_hi", bus.m_d_ready, 1'b1); tick();
        bus.m_d_valid = 1'b0;

        // Reset on beat 4 of an 8-beat Put aborts it; client 1 is then granted at once.
        for (int b = 0; b < 3; b++) begin
            set_client(0, 1'b1, 3'd0, 4'd6, 4'd1, 64'h800, 64'(b));
            eval(); tick();
        end
        rst = 1'b1;
        eval(); chk("t5_rst_valid", bus.m_a_valid, 1'b0); tick();
        rst = 1'b0;
        gv[0] = 1'b0;
        set_client(1, 1'b1, 3'd4, 4'd3, 4'd9, 64'h900, 64'h0);
        eval();
        chk("t5_grant", bus.grant_idx, 1'b1);
        chk("t5_busy", bus.busy, 1'b0);
        chk("t5_valid", bus.m_a_valid, 1'b1);
        tick();
        gv[1] = 1'b0;

        // D index outside the client range is dropped; in-range index routes normally.
        bus3.m_d_valid = 1'b1; bus3.m_d_source = 6'h35; bus3.c_d_ready = 3'b000;
        #1;
        chk("t6_drop_valid", bus3.c_d_valid, 3'b000);
        chk("t6_drop_ready", bus3.m_d_ready, 1'b1);
        bus3.m_d_source = 6'h25; bus3.c_d_ready = 3'b011;
        #1;
        chk("t6_route_valid", bus3.c_d_valid, 3'b100);
        chk("t6_route_ready", bus3.m_d_ready, 1'b0);
        bus3.m_d_valid = 1'b0;
        tick();

        // Randomized traffic obeying valid/payload stability until handshake.
        for (int i = 0; i < N; i++) g_left[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = (cyc == 0) || ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (!gv[i]) begin
                    if (g_left[i] == 0) begin
                        if ($urandom_range(0, 3) != 0) begin
                            case ($urandom_range(0, 3))
                                0:       f_op[i] = 3'd0;
                                1:       f_op[i] = 3'd1;
                                default: f_op[i] = 3'd4;
                            endcase
                            f_sz[i]   = 4'($urandom_range(0, 6));
                            f_src[i]  = 4'($urandom);
                            f_addr[i] = {$urandom, $urandom};
                            g_left[i] = beats_of(int'(f_op[i]), int'(f_sz[i]));
                            gv[i] = 1'b1;
                        end
                    end else if ($urandom_range(0, 3) != 0) begin
                        gv[i] = 1'b1;
                    end
                    f_param[i] = 3'($urandom);
                    f_mask[i]  = 8'($urandom);
                    f_data[i]  = {$urandom, $urandom};
                end
            end
            bus.m_a_ready  = ($urandom_range(0, 3) != 0);
            bus.m_d_valid  = 1'($urandom);
            bus.m_d_source = 5'($urandom);
            bus.c_d_ready  = 2'($urandom);
            bus.m_d_opcode = 3'($urandom);
            bus.m_d_param  = 2'($urandom);
            bus.m_d_size   = 4'($urandom);
            bus.m_d_sink   = 4'($urandom);
            bus.m_d_denied = 1'($urandom);
            bus.m_d_data   = {$urandom, $urandom};
            eval();
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    gv[i] = 1'b0;
                    g_left[i] = 0;
                end else if (exp_rdy[i]) begin
                    gv[i] = 1'b0;
                    g_left[i]--;
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
